// File: rtl/music_pkg.sv
// Shared types and helpers for the music player playback engine.
package music_pkg;

  typedef enum logic [2:0] {
    MODE_ORDER   = 3'd0,
    MODE_SHUFFLE = 3'd1,
    MODE_SELECT  = 3'd2,
    MODE_RECORD  = 3'd3,
    MODE_REPLAY  = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_NEXT   = 3'd2,
    ST_REC    = 3'd3,
    ST_REPLAY = 3'd4
  } state_e;

  // note * phase_num / sample_hz, truncated; callers narrow the result
  function automatic logic [63:0] phase_scale(input logic [63:0] note,
                                              input logic [63:0] phase_num,
                                              input logic [63:0] sample_hz);
    return (note * phase_num) / sample_hz;
  endfunction

  // Fold an index in [0, 2n) back into [0, n)
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rec_buffer.sv
// Key-record buffer: simple dual-port RAM with one-clock registered read.
module rec_buffer #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so recordings survive a reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/playlist_sequencer.sv
// Playback engine: order/shuffle/select ROM playback, key record/replay, DDS increment out.
// Optional SHUFFLE_NOREPEAT_EN: shuffle never repeats the song just played.
module playlist_sequencer
  import music_pkg::*;
#(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned NOTE_W    = 16,
  parameter logic [NUM_SONGS*ADDR_W-1:0] SONG_LEN = {11'd270, 11'd220, 11'd260, 11'd260},
  parameter int unsigned REC_DEPTH = 512,
  parameter int unsigned PHASE_NUM = 65536,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         pause,
  input  logic [2:0]                   mode,
  input  logic [$clog2(NUM_SONGS)-1:0] choice,
  input  logic [$clog2(NUM_SONGS)-1:0] rand_val,
  output logic [$clog2(NUM_SONGS)-1:0] rom_sel,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [NOTE_W-1:0]            rom_data,
  input  logic [NOTE_W-1:0]            key_note,
  input  logic                         key_valid,
  output logic [NOTE_W-1:0]            phase_inc,
  output logic [$clog2(NUM_SONGS)-1:0] cur_song,
  output logic                         song_done,
  output logic [ADDR_W:0]              rec_count
);

  localparam int unsigned SW  = $clog2(NUM_SONGS);
  localparam int unsigned RAW = $clog2(REC_DEPTH);
  localparam int unsigned CW  = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [2:0]        act_mode_q, act_mode_d;
  logic [SW-1:0]     cur_song_q, cur_song_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [RAW-1:0]    rp_addr_q, rp_addr_d;
  logic [CW-1:0]     rec_count_d;
  logic              song_done_d;
  logic [NOTE_W-1:0] phase_d;
  logic              wr_en_c;
  logic              step_c;
  logic              mode_chg_c;
  logic [ADDR_W-1:0] song_len_c;
  logic [SW-1:0]     choice_c;
  logic [SW-1:0]     shuf_c;
  logic [SW-1:0]     order_c;
  logic [NOTE_W-1:0] note_c;
  logic [NOTE_W-1:0] buf_data;

  assign rom_sel  = cur_song_q;
  assign cur_song = cur_song_q;

  rec_buffer #(
    .DEPTH  (REC_DEPTH),
    .DATA_W (NOTE_W),
    .AW     (RAW)
  ) u_rec_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (rec_count[RAW-1:0]),
    .wr_data (key_note),
    .rd_addr (rp_addr_q),
    .rd_data (buf_data)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    act_mode_d  = act_mode_q;
    cur_song_d  = cur_song_q;
    rom_addr_d  = rom_addr;
    rp_addr_d   = rp_addr_q;
    rec_count_d = rec_count;
    song_done_d = 1'b0;
    wr_en_c     = 1'b0;
    step_c      = tick && !pause;
    mode_chg_c  = (mode != act_mode_q);
    song_len_c  = SONG_LEN[32'(cur_song_q) * ADDR_W +: ADDR_W];
    choice_c    = SW'(wrap_idx(32'(choice), NUM_SONGS));
    order_c     = SW'(wrap_idx(32'(cur_song_q) + 32'd1, NUM_SONGS));
    shuf_c      = SW'(wrap_idx(32'(rand_val), NUM_SONGS));
`ifdef SHUFFLE_NOREPEAT_EN
    if (shuf_c == cur_song_q) shuf_c = order_c;
`endif

    case (state_q)
      ST_IDLE: begin
        rom_addr_d = '0;
        rp_addr_d  = '0;
        if (step_c) begin
          act_mode_d = mode;
          case (mode)
            MODE_ORDER, MODE_SHUFFLE: state_d = ST_PLAY;
            MODE_SELECT: begin
              state_d    = ST_PLAY;
              cur_song_d = choice_c;
            end
            MODE_RECORD: begin
              state_d     = ST_REC;
              rec_count_d = '0;
            end
            MODE_REPLAY: state_d = ST_REPLAY;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_PLAY: begin
        if (step_c) begin
          if (mode_chg_c) begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
          end else if (act_mode_q == MODE_SELECT && choice_c != cur_song_q) begin
            cur_song_d = choice_c;
            rom_addr_d = '0;
          end else if (rom_addr >= song_len_c) begin
            rom_addr_d  = '0;
            song_done_d = 1'b1;
            state_d     = ST_NEXT;
          end else begin
            rom_addr_d = rom_addr + ADDR_W'(1);
          end
        end
      end
      ST_NEXT: begin
        state_d = ST_PLAY;
        case (act_mode_q)
          MODE_SHUFFLE: cur_song_d = shuf_c;
          MODE_SELECT:  cur_song_d = choice_c;
          default:      cur_song_d = order_c;
        endcase
      end
      ST_REC: begin
        // A key press wins over a coincident tick
        if (key_valid && !pause) begin
          if (rec_count < CW'(REC_DEPTH)) begin
            wr_en_c     = 1'b1;
            rec_count_d = rec_count + CW'(1);
          end
        end else if (step_c && mode_chg_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        if (step_c) begin
          if (mode_chg_c) begin
            state_d   = ST_IDLE;
            rp_addr_d = '0;
          end else if (rec_count != '0) begin
            if ((CW'(rp_addr_q) + CW'(1)) >= rec_count) rp_addr_d = '0;
            else                                        rp_addr_d = rp_addr_q + RAW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_q)
      ST_PLAY, ST_NEXT: note_c = rom_data;
      ST_REPLAY:        note_c = (rec_count != '0) ? buf_data : '0;
      default:          note_c = '0;
    endcase
    phase_d = pause ? '0 : NOTE_W'(phase_scale(64'(note_c), 64'(PHASE_NUM), 64'(SAMPLE_HZ)));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_mode_q <= 3'd0;
      cur_song_q <= '0;
      rom_addr   <= '0;
      rp_addr_q  <= '0;
      rec_count  <= '0;
      song_done  <= 1'b0;
      phase_inc  <= '0;
    end else begin
      state_q    <= state_d;
      act_mode_q <= act_mode_d;
      cur_song_q <= cur_song_d;
      rom_addr   <= rom_addr_d;
      rp_addr_q  <= rp_addr_d;
      rec_count  <= rec_count_d;
      song_done  <= song_done_d;
      phase_inc  <= phase_d;
    end
  end

endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed self-checking bench for playlist_sequencer; songs 0-2 end at address 3, song 3 at 150.
module tb_playlist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        pause = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [1:0]  choice = 2'd0;
  logic [1:0]  rand_val = 2'd0;
  logic [1:0]  rom_sel;
  logic [10:0] rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic [15:0] key_note = 16'd0;
  logic        key_valid = 1'b0;
  logic [15:0] phase_inc;
  logic [1:0]  cur_song;
  logic        song_done;
  logic [11:0] rec_count;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] rec_notes [5] = '{16'd262, 16'd294, 16'd330, 16'd349, 16'd392};
  logic [15:0] rep_exp   [5] = '{16'd357, 16'd401, 16'd450, 16'd476, 16'd535};
  logic [1:0]  shuf_exp;

  playlist_sequencer #(
    .NUM_SONGS (4),
    .ADDR_W    (11),
    .NOTE_W    (16),
    .SONG_LEN  ({11'd150, 11'd3, 11'd3, 11'd3}),
    .REC_DEPTH (512),
    .PHASE_NUM (65536),
    .SAMPLE_HZ (48000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .pause     (pause),
    .mode      (mode),
    .choice    (choice),
    .rand_val  (rand_val),
    .rom_sel   (rom_sel),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .key_note  (key_note),
    .key_valid (key_valid),
    .phase_inc (phase_inc),
    .cur_song  (cur_song),
    .song_done (song_done),
    .rec_count (rec_count)
  );

  always #5 clk = ~clk;

  // Registered-read ROM: song 2 holds 880 Hz, the others 440 Hz
  always @(posedge clk) rom_data <= (rom_sel == 2'd2) ? 16'd880 : 16'd440;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_once();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; pause = 1'b0; key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    n_total++; if (rom_addr !== 11'd0)  $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);  else n_pass++;
    n_total++; if (rom_sel !== 2'd0)    $display("FAIL reset_rom_sel: got %0d want 0", rom_sel);    else n_pass++;
    n_total++; if (cur_song !== 2'd0)   $display("FAIL reset_cur_song: got %0d want 0", cur_song);  else n_pass++;
    n_total++; if (phase_inc !== 16'd0) $display("FAIL reset_phase: got %0d want 0", phase_inc);    else n_pass++;
    n_total++; if (rec_count !== 12'd0) $display("FAIL reset_rec_count: got %0d want 0", rec_count); else n_pass++;
    n_total++; if (song_done !== 1'b0)  $display("FAIL reset_song_done: got %0d want 0", song_done); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_order();
    do_reset();
    mode = 3'd0;
    tick_once();
    wait_cyc(3);
    n_total++; if (phase_inc !== 16'd600) $display("FAIL order_phase: got %0d want 600", phase_inc); else n_pass++;
    repeat (3) tick_once();
    n_total++; if (rom_addr !== 11'd3) $display("FAIL order_addr3: got %0d want 3", rom_addr); else n_pass++;
    tick_once();
    n_total++; if (song_done !== 1'b1) $display("FAIL order_done0: got %0d want 1", song_done); else n_pass++;
    n_total++; if (rom_addr !== 11'd0) $display("FAIL order_wrap_addr: got %0d want 0", rom_addr); else n_pass++;
    wait_cyc(1);
    n_total++; if (cur_song !== 2'd1)  $display("FAIL order_song1: got %0d want 1", cur_song); else n_pass++;
    n_total++; if (song_done !== 1'b0) $display("FAIL order_done_pulse: got %0d want 0", song_done); else n_pass++;
    repeat (4) tick_once();
    wait_cyc(1);
    n_total++; if (rom_sel !== 2'd2) $display("FAIL order_sel2: got %0d want 2", rom_sel); else n_pass++;
    wait_cyc(3);
    n_total++; if (phase_inc !== 16'd1201) $display("FAIL order_phase880: got %0d want 1201", phase_inc); else n_pass++;
    repeat (4) tick_once();
    wait_cyc(1);
    n_total++; if (cur_song !== 2'd3) $display("FAIL order_song3: got %0d want 3", cur_song); else n_pass++;
    repeat (150) tick_once();
    n_total++; if (rom_addr !== 11'd150) $display("FAIL order_addr150: got %0d want 150", rom_addr); else n_pass++;
    tick_once();
    n_total++; if (song_done !== 1'b1) $display("FAIL order_done3: got %0d want 1", song_done); else n_pass++;
    wait_cyc(1);
    n_total++; if (cur_song !== 2'd0) $display("FAIL order_wrap_song: got %0d want 0", cur_song); else n_pass++;
  endtask

  task automatic test_select_pause();
    do_reset();
    mode = 3'd2; choice = 2'd0;
    tick_once();
    repeat (2) tick_once();
    n_total++; if (rom_addr !== 11'd2) $display("FAIL sel_addr2: got %0d want 2", rom_addr); else n_pass++;
    choice = 2'd2;
    tick_once();
    n_total++; if (rom_sel !== 2'd2)   $display("FAIL sel_rom_sel: got %0d want 2", rom_sel);   else n_pass++;
    n_total++; if (rom_addr !== 11'd0) $display("FAIL sel_restart: got %0d want 0", rom_addr); else n_pass++;
    wait_cyc(3);
    n_total++; if (phase_inc !== 16'd1201) $display("FAIL sel_phase: got %0d want 1201", phase_inc); else n_pass++;
    tick_once();
    pause = 1'b1;
    repeat (10) tick_once();
    n_total++; if (rom_addr !== 11'd1)  $display("FAIL pause_addr: got %0d want 1", rom_addr);  else n_pass++;
    n_total++; if (phase_inc !== 16'd0) $display("FAIL pause_phase: got %0d want 0", phase_inc); else n_pass++;
    pause = 1'b0;
    wait_cyc(3);
    n_total++; if (phase_inc !== 16'd1201) $display("FAIL resume_phase: got %0d want 1201", phase_inc); else n_pass++;
    tick_once();
    n_total++; if (rom_addr !== 11'd2) $display("FAIL resume_addr: got %0d want 2", rom_addr); else n_pass++;
  endtask

  task automatic test_record_replay();
    do_reset();
    mode = 3'd3;
    tick_once();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_valid = 1'b1; key_note = rec_notes[i];
      // Last key lands together with a tick that must be ignored
      if (i == 4) begin mode = 3'd4; tick = 1'b1; end
    end
    @(negedge clk);
    key_valid = 1'b0; tick = 1'b0;
    n_total++; if (rec_count !== 12'd5) $display("FAIL rec_count5: got %0d want 5", rec_count); else n_pass++;
    tick_once();
    tick_once();
    wait_cyc(3);
    n_total++; if (phase_inc !== rep_exp[0]) $display("FAIL replay_0: got %0d want %0d", phase_inc, rep_exp[0]); else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      tick_once();
      wait_cyc(3);
      n_total++;
      if (phase_inc !== rep_exp[i % 5]) $display("FAIL replay_%0d: got %0d want %0d", i, phase_inc, rep_exp[i % 5]);
      else n_pass++;
    end
  endtask

  task automatic test_record_full();
    mode = 3'd3;
    tick_once();
    tick_once();
    n_total++; if (rec_count !== 12'd0) $display("FAIL full_clear: got %0d want 0", rec_count); else n_pass++;
    @(negedge clk);
    key_valid = 1'b1;
    for (int i = 0; i < 515; i++) begin
      key_note = 16'(i + 100);
      @(negedge clk);
    end
    key_valid = 1'b0;
    n_total++; if (rec_count !== 12'd512) $display("FAIL full_count: got %0d want 512", rec_count); else n_pass++;
  endtask

  task automatic test_shuffle();
    do_reset();
    mode = 3'd1; rand_val = 2'd1;
    tick_once();
    repeat (4) tick_once();
    wait_cyc(1);
    n_total++; if (cur_song !== 2'd1) $display("FAIL shuf_first: got %0d want 1", cur_song); else n_pass++;
`ifdef SHUFFLE_NOREPEAT_EN
    shuf_exp = 2'd2;
`else
    shuf_exp = 2'd1;
`endif
    repeat (4) tick_once();
    wait_cyc(1);
    n_total++; if (cur_song !== shuf_exp) $display("FAIL shuf_repeat: got %0d want %0d", cur_song, shuf_exp); else n_pass++;
  endtask

  task automatic test_invalid_mode();
    mode = 3'd5;
    tick_once();
    wait_cyc(3);
    n_total++; if (phase_inc !== 16'd0) $display("FAIL inv_phase: got %0d want 0", phase_inc); else n_pass++;
    repeat (2) tick_once();
    n_total++; if (rom_addr !== 11'd0) $display("FAIL inv_addr: got %0d want 0", rom_addr); else n_pass++;
  endtask

  task automatic test_reset_mid_song();
    do_reset();
    mode = 3'd2; choice = 2'd3;
    tick_once();
    repeat (100) tick_once();
    n_total++; if (rom_addr !== 11'd100) $display("FAIL mid_addr100: got %0d want 100", rom_addr); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (rom_addr !== 11'd0)  $display("FAIL mid_rst_addr: got %0d want 0", rom_addr);   else n_pass++;
    n_total++; if (cur_song !== 2'd0)   $display("FAIL mid_rst_song: got %0d want 0", cur_song);   else n_pass++;
    n_total++; if (phase_inc !== 16'd0) $display("FAIL mid_rst_phase: got %0d want 0", phase_inc); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; mode = 3'd0;
    tick_once();
    n_total++; if (rom_addr !== 11'd0) $display("FAIL mid_idle_entry: got %0d want 0", rom_addr); else n_pass++;
    tick_once();
    n_total++; if (rom_addr !== 11'd1) $display("FAIL mid_resume: got %0d want 1", rom_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_order();
    test_select_pause();
    test_record_replay();
    test_record_full();
    test_shuffle();
    test_invalid_mode();
    test_reset_mid_song();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
